// File: rtl/fir_interp.sv
// Polyphase interpolating FIR. Each input sample read from the input FIFO
// produces INTERP output samples. Every output phase p is the dot product of
// the M = TAPS/INTERP newest samples with the sub-filter
// COEFF[p], COEFF[p+INTERP], ... Each product is dequantized before it is
// accumulated. One tap is processed per clock cycle.
module fir_interp #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 32,
    parameter int INTERP     = 8,
    parameter int BITS       = 10,
    parameter logic signed [DATA_WIDTH-1:0] COEFF [TAPS] = '{
        -1,    0,    0,    2,    4,    8,   11,   12,
         8,   -1,  -18,  -41,  -69,  -97, -121, -138,
      -138, -121,  -97,  -69,  -41,  -18,   -1,    8,
        12,   11,    8,    4,    2,    0,    0,   -1
    }
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  x_empty,
    output logic                  x_rd_en,
    output logic [DATA_WIDTH-1:0] y_out,
    input  logic                  y_out_full,
    output logic                  y_wr_en
);

    localparam int M    = TAPS / INTERP;
    localparam int PH_W = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int K_W  = (M > 1) ? $clog2(M) : 1;
    localparam int CI_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    // Adding 2^BITS-1 to negative values before the arithmetic shift turns
    // floor division into truncation toward zero.
    localparam logic signed [DATA_WIDTH-1:0] DEQ_BIAS = DATA_WIDTH'((1 << BITS) - 1);

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                         state_q,   state_d;
    logic        [PH_W-1:0]         phase_q,   phase_d;
    logic        [K_W-1:0]          k_q,       k_d;
    logic signed [DATA_WIDTH-1:0]   acc_q,     acc_d;
    logic signed [DATA_WIDTH-1:0]   hist_q [M];
    logic signed [DATA_WIDTH-1:0]   hist_d [M];
    logic        [DATA_WIDTH-1:0]   y_out_q,   y_out_d;
    logic                           y_wr_en_q, y_wr_en_d;

    logic        [CI_W-1:0]         coef_idx;
    logic signed [DATA_WIDTH-1:0]   coef_s;
    logic signed [DATA_WIDTH-1:0]   tap_s;
    logic signed [DATA_WIDTH-1:0]   prod;
    logic signed [DATA_WIDTH-1:0]   prod_deq;

    // Signed divide by 2^BITS, rounding toward zero.
    function automatic logic signed [DATA_WIDTH-1:0] deq(
        input logic signed [DATA_WIDTH-1:0] p
    );
        logic signed [DATA_WIDTH-1:0] biased;
        biased = p[DATA_WIDTH-1] ? (p + DEQ_BIAS) : p;
        return biased >>> BITS;
    endfunction

    // Tap product for the current (phase, k): low DATA_WIDTH bits, then dequantized.
    always_comb begin
        coef_idx = CI_W'(phase_q) + CI_W'(k_q) * CI_W'(INTERP);
        coef_s   = COEFF[coef_idx];
        tap_s    = hist_q[k_q];
        prod     = coef_s * tap_s;
        prod_deq = deq(prod);
    end

    // Next-state and output logic: read, M multiply-accumulate cycles, write, repeated per phase.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        k_d       = k_q;
        acc_d     = acc_q;
        hist_d    = hist_q;
        y_out_d   = y_out_q;
        y_wr_en_d = 1'b0;
        x_rd_en   = 1'b0;

        case (state_q)
            S_READ: begin
                x_rd_en = !x_empty;
                if (!x_empty) begin
                    for (int j = M - 1; j > 0; j--) begin
                        hist_d[j] = hist_q[j-1];
                    end
                    hist_d[0] = x_in;
                    phase_d   = '0;
                    k_d       = '0;
                    acc_d     = '0;
                    state_d   = S_MAC;
                end
            end

            S_MAC: begin
                acc_d = acc_q + prod_deq;
                if (k_q == K_W'(M - 1)) begin
                    state_d = S_WRITE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            S_WRITE: begin
                // A full output FIFO freezes the whole state until space frees up.
                if (!y_out_full) begin
                    y_out_d   = acc_q;
                    y_wr_en_d = 1'b1;
                    if (phase_q == PH_W'(INTERP - 1)) begin
                        state_d = S_READ;
                    end else begin
                        phase_d = phase_q + 1'b1;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = S_MAC;
                    end
                end
            end

            default: begin
                state_d = S_READ;
            end
        endcase
    end

    // State, history, accumulator and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_READ;
            phase_q   <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_wr_en_q <= 1'b0;
            for (int j = 0; j < M; j++) begin
                hist_q[j] <= '0;
            end
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            y_out_q   <= y_out_d;
            y_wr_en_q <= y_wr_en_d;
            for (int j = 0; j < M; j++) begin
                hist_q[j] <= hist_d[j];
            end
        end
    end

    assign y_out   = y_out_q;
    assign y_wr_en = y_wr_en_q;

endmodule

// File: tb/tb_fir_interp.sv
// Testbench for fir_interp. A queue stands in for the input FIFO. A behavioural
// model computes every output phase directly as a sum of dequantized
// coefficient*sample products, and the DUT's write stream is scored against
// the resulting queue of expected outputs.
module tb_fir_interp;

    localparam int DATA_WIDTH = 32;
    localparam int TAPS       = 32;
    localparam int INTERP     = 8;
    localparam int BITS       = 10;
    localparam int M          = TAPS / INTERP;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [DATA_WIDTH-1:0] x_in = '0;
    logic                  x_empty = 1'b1;
    logic                  x_rd_en;
    logic [DATA_WIDTH-1:0] y_out;
    logic                  y_out_full = 1'b0;
    logic                  y_wr_en;

    always #5 clock = ~clock;

    fir_interp dut (
        .clock      (clock),
        .reset      (reset),
        .x_in       (x_in),
        .x_empty    (x_empty),
        .x_rd_en    (x_rd_en),
        .y_out      (y_out),
        .y_out_full (y_out_full),
        .y_wr_en    (y_wr_en)
    );

    int tests  = 0;
    int fails  = 0;
    int nreads = 0;
    int in_q[$];
    int exp_q[$];
    int cap_q[$];
    int m_hist[M];
    int coef[TAPS] = '{
        -1,    0,    0,    2,    4,    8,   11,   12,
         8,   -1,  -18,  -41,  -69,  -97, -121, -138,
      -138, -121,  -97,  -69,  -41,  -18,   -1,    8,
        12,   11,    8,    4,    2,    0,    0,   -1
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Reference: on each input, shift history and emit all INTERP phases.
    task automatic model_read(input int v);
        int acc;
        for (int j = M - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = v;
        for (int p = 0; p < INTERP; p++) begin
            acc = 0;
            for (int k = 0; k < M; k++) begin
                acc += (coef[p + k*INTERP] * m_hist[k]) / (1 << BITS);
            end
            exp_q.push_back(acc);
        end
    endtask

    task automatic drive();
        x_empty = (in_q.size() == 0);
        x_in    = (in_q.size() != 0) ? in_q[0] : 0;
    endtask

    // One clock: score outputs at the falling edge, update the FIFO model after the rising edge.
    task automatic cycle();
        logic rd;
        logic rst_edge;
        @(negedge clock);
        rd = x_rd_en;
        if (y_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write", y_wr_en, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                cap_q.push_back(int'(y_out));
                chk("y_out_seq", y_out, e);
            end
        end
        @(posedge clock);
        rst_edge = reset;
        #1;
        if (rd === 1'b1 && !rst_edge && in_q.size() != 0) begin
            model_read(in_q.pop_front());
            nreads++;
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        in_q.delete();
        exp_q.delete();
        cap_q.delete();
        nreads = 0;
        for (int j = 0; j < M; j++) m_hist[j] = 0;
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < 4000) begin
            cycle();
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (M + 4) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int n;

        // Reset state
        do_reset();
        do_reset();
        chk("rst_y_wr_en", y_wr_en, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_x_rd_en", x_rd_en, 0);

        // Impulse: outputs reproduce the prototype coefficients in order
        in_q = '{1024, 0, 0, 0};
        drive();
        drain();
        chk("imp_count", cap_q.size(), TAPS);
        for (int i = 0; i < TAPS; i++) begin
            if (i < cap_q.size()) chk("imp_coef", cap_q[i], coef[i]);
        end
        chk("imp_reads", nreads, 4);

        // DC: steady-state phase sums (phase 7 mirrors phase 0 by symmetry)
        do_reset();
        for (int i = 0; i < 6; i++) in_q.push_back(1024);
        drive();
        drain();
        chk("dc_count", cap_q.size(), 6 * INTERP);
        if (cap_q.size() >= 48) begin
            chk("dc_phase0", cap_q[24], -119);
            chk("dc_phase7", cap_q[31], -119);
            chk("dc_repeat", cap_q[47], cap_q[39]);
        end

        // Truncation toward zero on negative products
        do_reset();
        in_q.push_back(1536);
        drive();
        drain();
        chk("trunc_count", cap_q.size(), INTERP);
        if (cap_q.size() >= 4) begin
            chk("trunc_first", cap_q[0], -1);
            chk("trunc_fourth", cap_q[3], 3);
        end

        // Random samples with a 20-cycle backpressure hold, then random backpressure
        do_reset();
        for (int i = 0; i < 12; i++) in_q.push_back(int'($urandom()));
        for (int i = 0; i < 12; i++) in_q.push_back(int'($urandom_range(0, 200000)) - 100000);
        drive();
        repeat (30) cycle();
        held = y_out;
        y_out_full = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("bp_wr_en", y_wr_en, 0);
            chk("bp_y_hold", y_out, held);
        end
        y_out_full = 1'b0;
        for (int i = 0; i < 300; i++) begin
            y_out_full = ($urandom_range(0, 3) == 0);
            cycle();
        end
        y_out_full = 1'b0;
        drain();
        chk("rand_reads", nreads, 24);

        // Empty stall then resume
        for (int i = 0; i < 50; i++) begin
            cycle();
            chk("stall_rd_en", x_rd_en, 0);
            chk("stall_wr_en", y_wr_en, 0);
        end
        in_q.push_back(int'($urandom_range(0, 5000)));
        drive();
        #1;
        chk("resume_rd_en", x_rd_en, 1);
        drain();

        // Reset during phase 3 of an impulse
        do_reset();
        in_q.push_back(1024);
        drive();
        n = 0;
        while (cap_q.size() < 3 && n < 200) begin
            cycle();
            n++;
        end
        chk("mid_reached", cap_q.size(), 3);
        do_reset();
        chk("mid_rst_wr_en", y_wr_en, 0);
        chk("mid_rst_y_out", y_out, 0);
        chk("mid_rst_rd_idle", x_rd_en, 0);
        in_q = '{1024, 0, 0, 0};
        drive();
        #1;
        chk("mid_rst_rd_follow", x_rd_en, 1);
        drain();
        chk("mid_imp_count", cap_q.size(), TAPS);
        for (int i = 0; i < TAPS; i++) begin
            if (i < cap_q.size()) chk("mid_imp_coef", cap_q[i], coef[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
